pocket_bridge_spi: RTL and testbench

Core-side target for the Pocket bridge dual-line SPI link. Sits directly downstream of the bridge SPI host and deserialises its 2-bit-per-clock command frames into 32-bit bus transactions (address, write data, read request) in the core clock domain. For reads, it returns the 32-bit read data to the host over the same two lines. The top level owns the inout pads: it feeds `spi_d_in` from them and drives them with `spi_d_out` when `spi_d_oe` is high.

---
 rtl/pocket_bridge_spi.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_pocket_bridge_spi.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pocket_bridge_spi.sv
// pocket_bridge_spi
// -----------------------------------------------------------------------------
// Core-side target of the Pocket bridge dual-line SPI link. Deserialises 2-bit
// symbols from the bridge host into 32-bit bus transactions in the clk domain
// and, for reads, serialises the 32-bit read data back over the same two lines.
//
// Wire format: each byte is sent least-significant symbol first
// ([1:0], [3:2], [5:4], [7:6]); bytes go most-significant byte first; one
// word is 16 symbols. The first word of a frame is the address, and address
// bit 0 selects write (1) or read (0).
//
// Ports:
//   clk, rst_n    core clock, asynchronous active-low reset
//   spi_clk       bridge SPI clock (asynchronous, at most clk/8)
//   spi_ss        frame select, active-low
//   spi_d_in[1:0] symbol from the pads (bit 1 MOSI, bit 0 MISO)
//   spi_d_out     symbol toward the host, same bit mapping
//   spi_d_oe      pad drive enable
//   bus_addr      transaction address, bit 0 always 0
//   bus_wdata     write data
//   bus_wr/bus_rd request levels
//   bus_rdata     read data, captured with bus_ack
//   bus_ack       one-cycle completion strobe
//   frame_err     one-cycle pulse on an aborted frame or a late read ack
//   fsm_state     current frame state, for debug and checkers
//
// Bus handshake: bus_wr/bus_rd act as "valid" and stay high, with bus_addr
// and bus_wdata stable, until the cycle in which bus_ack is seen high; that
// cycle completes the transaction and the request drops on the next edge.
// bus_ack with no request open is ignored.
// -----------------------------------------------------------------------------
module pocket_bridge_spi #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_clk,
  input  logic        spi_ss,
  input  logic [1:0]  spi_d_in,
  output logic [1:0]  spi_d_out,
  output logic        spi_d_oe,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_wr,
  output logic        bus_rd,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        frame_err,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_WACK  = 3'd3,
    S_RTURN = 3'd4,
    S_RDATA = 3'd5,
    S_DONE  = 3'd6,
    S_DRAIN = 3'd7   // frame over, waiting for an outstanding bus_ack
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge strobes.
  // All four input bits go through the same depth, so a sampled symbol is
  // aligned with the spi_clk edge that qualifies it. One extra register stage
  // turns the synchronised levels into registered edge strobes.
  // The select synchroniser resets to 0 so that a host still holding spi_ss
  // low when reset is released does not look like the start of a new frame.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] d1_sync;
  logic [SYNC_STAGES-1:0] d0_sync;
  logic                   clk_prev;
  logic                   ss_prev;
  logic                   clk_rise;
  logic                   clk_fall;
  logic                   ss_rise;
  logic                   ss_fall;
  logic [1:0]             sym;

  logic clk_s;
  logic ss_s;
  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign ss_s  = ss_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '0;
      ss_sync  <= '0;
      d1_sync  <= '0;
      d0_sync  <= '0;
      clk_prev <= 1'b0;
      ss_prev  <= 1'b0;
      clk_rise <= 1'b0;
      clk_fall <= 1'b0;
      ss_rise  <= 1'b0;
      ss_fall  <= 1'b0;
      sym      <= 2'b00;
    end else begin
      clk_sync <= (clk_sync << 1) | SYNC_STAGES'(spi_clk);
      ss_sync  <= (ss_sync << 1)  | SYNC_STAGES'(spi_ss);
      d1_sync  <= (d1_sync << 1)  | SYNC_STAGES'(spi_d_in[1]);
      d0_sync  <= (d0_sync << 1)  | SYNC_STAGES'(spi_d_in[0]);
      clk_prev <= clk_s;
      ss_prev  <= ss_s;
      clk_rise <= clk_s & ~clk_prev;
      clk_fall <= ~clk_s & clk_prev;
      ss_rise  <= ss_s & ~ss_prev;
      ss_fall  <= ~ss_s & ss_prev;
      sym      <= {d1_sync[SYNC_STAGES-1], d0_sync[SYNC_STAGES-1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Symbol position. For symbol count c, the byte is 3 - c[3:2] (MSB byte
  // first) and the pair within the byte is c[1:0] (LSB pair first), so the
  // word bit index is {~c[3:2], c[1:0], 0}. The same mapping is used for
  // shifting in and shifting out.
  // ---------------------------------------------------------------------------
  logic [3:0]  cnt;
  logic [4:0]  sym_idx;
  logic [31:0] shreg;
  logic [31:0] word_in;

  assign sym_idx = {~cnt[3:2], cnt[1:0], 1'b0};

  always_comb begin
    word_in = shreg;
    word_in[sym_idx +: 2] = sym;
  end

  // A request is still open after this cycle if it is high and not acked now.
  logic req_open;
  assign req_open = (bus_rd | bus_wr) & ~bus_ack;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t state;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      shreg     <= '0;
      spi_d_out <= 2'b00;
      spi_d_oe  <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wr    <= 1'b0;
      bus_rd    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      // Completion is honoured in every state, so an ack arriving together
      // with an abort or after a late read still closes the request.
      if (bus_ack) begin
        bus_wr <= 1'b0;
        bus_rd <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          spi_d_oe  <= 1'b0;
          spi_d_out <= 2'b00;
          if (ss_fall) begin
            state <= S_ADDR;
            cnt   <= 4'd0;
            shreg <= '0;
          end
        end

        S_ADDR: begin
          if (ss_rise) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end else if (clk_rise) begin
            cnt   <= cnt + 4'd1;
            shreg <= word_in;
            if (cnt == 4'd15) begin
              bus_addr <= {word_in[31:1], 1'b0};
              shreg    <= '0;
              if (word_in[0]) begin
                state <= S_WDATA;
              end else begin
                state  <= S_RTURN;
                bus_rd <= 1'b1;
              end
            end
          end
        end

        S_WDATA: begin
          // An abort here drops the write; nothing has reached the bus yet.
          if (ss_rise) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end else if (clk_rise) begin
            cnt   <= cnt + 4'd1;
            shreg <= word_in;
            if (cnt == 4'd15) begin
              bus_wdata <= word_in;
              bus_wr    <= 1'b1;
              state     <= S_WACK;
            end
          end
        end

        S_WACK: begin
          // The host normally closes the frame right after the data word, so
          // spi_ss rising here is not an error; it only decides where to wait.
          if (bus_ack) begin
            state <= ss_rise ? S_IDLE : S_DONE;
          end else if (ss_rise) begin
            state <= S_DRAIN;
          end
        end

        S_RTURN: begin
          if (bus_rd && bus_ack) begin
            shreg <= bus_rdata;
          end
          if (ss_rise) begin
            frame_err <= 1'b1;
            spi_d_oe  <= 1'b0;
            spi_d_out <= 2'b00;
            state     <= req_open ? S_DRAIN : S_IDLE;
          end else begin
            if (clk_fall) begin
              spi_d_oe  <= 1'b1;
              spi_d_out <= 2'b00;
            end
            if (clk_rise) begin
              cnt <= cnt + 4'd1;
              if (cnt == 4'd3) begin
                cnt   <= 4'd0;
                state <= S_RDATA;
                // Ack missed the deadline: send zeros and let the late data
                // fall on the floor when it eventually arrives.
                if (req_open) begin
                  frame_err <= 1'b1;
                  shreg     <= '0;
                end
              end
            end
          end
        end

        S_RDATA: begin
          if (ss_rise) begin
            frame_err <= 1'b1;
            spi_d_oe  <= 1'b0;
            spi_d_out <= 2'b00;
            state     <= req_open ? S_DRAIN : S_IDLE;
          end else begin
            if (clk_fall) begin
              spi_d_out <= shreg[sym_idx +: 2];
            end
            if (clk_rise) begin
              cnt <= cnt + 4'd1;
              if (cnt == 4'd15) begin
                state <= S_DONE;
              end
            end
          end
        end

        S_DONE: begin
          if (ss_rise) begin
            spi_d_oe  <= 1'b0;
            spi_d_out <= 2'b00;
            state     <= req_open ? S_DRAIN : S_IDLE;
          end
        end

        S_DRAIN: begin
          spi_d_oe  <= 1'b0;
          spi_d_out <= 2'b00;
          if (!req_open) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pocket_bridge_spi.sv
// tb_pocket_bridge_spi
// Self-checking bench for pocket_bridge_spi. A host model drives frames over
// spi_clk/spi_ss/spi_d_in; a bus responder acks requests after a programmable
// delay and logs each completed transaction. Expected transactions and host
// read data are derived from the frame contents at word level.
module tb_pocket_bridge_spi;

  localparam int HALF = 60;   // half spi_clk period; clk period is 10

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        spi_clk;
  logic        spi_ss;
  logic [1:0]  spi_d_in;
  logic [1:0]  spi_d_out;
  logic        spi_d_oe;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        frame_err;
  logic [2:0]  fsm_state;

  pocket_bridge_spi #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_clk   (spi_clk),
    .spi_ss    (spi_ss),
    .spi_d_in  (spi_d_in),
    .spi_d_out (spi_d_out),
    .spi_d_oe  (spi_d_oe),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .frame_err (frame_err),
    .fsm_state (fsm_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------------------------------------------------------------------
  // Scoreboard queues: {is_write, addr, wdata (0 for reads)}
  // ---------------------------------------------------------------------------
  logic [64:0] exp_q[$];
  logic [64:0] got_q[$];

  // ---------------------------------------------------------------------------
  // Bus responder
  // ---------------------------------------------------------------------------
  int          ack_delay = 3;
  bit          ack_en    = 1'b1;
  logic [31:0] rd_value  = '0;

  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      if (rst_n && (bus_wr || bus_rd) && ack_en) begin
        if (wait_cnt >= ack_delay) begin
          bus_ack   = 1'b1;
          bus_rdata = rd_value;
          got_q.push_back({bus_wr, bus_addr, bus_wr ? bus_wdata : 32'h0});
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Cycle monitors, sampled away from the active edge.
  int ferr_cnt = 0;
  int wr_hi    = 0;
  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (bus_wr)    wr_hi++;
  end

  // ---------------------------------------------------------------------------
  // Host driver tasks
  // ---------------------------------------------------------------------------
  function automatic int sym_pos(input int s);
    return (3 - s / 4) * 8 + (s % 4) * 2;
  endfunction

  task automatic host_sym(input logic [1:0] tx, output logic [1:0] rx,
                          output logic oe);
    spi_d_in = tx;
    #(HALF);
    rx = spi_d_out;
    oe = spi_d_oe;
    spi_clk = 1'b1;
    #(HALF);
    spi_clk = 1'b0;
  endtask

  task automatic send_syms(input logic [31:0] w, input int n);
    logic [1:0] rx;
    logic       oe;
    for (int s = 0; s < n; s++) begin
      host_sym(w[sym_pos(s) +: 2], rx, oe);
    end
  endtask

  task automatic recv_word(output logic [31:0] w);
    logic [1:0] rx;
    logic       oe;
    w = '0;
    for (int s = 0; s < 16; s++) begin
      host_sym(2'b00, rx, oe);
      w[sym_pos(s) +: 2] = rx;
    end
  endtask

  task automatic turnaround(output logic [7:0] bits, output logic all_oe);
    logic [1:0] rx;
    logic       oe;
    all_oe = 1'b1;
    bits   = '0;
    for (int k = 0; k < 4; k++) begin
      host_sym(2'b00, rx, oe);
      bits[2*k +: 2] = rx;
      all_oe = all_oe & oe;
    end
  endtask

  task automatic ss_begin();
    spi_ss = 1'b0;
    #(HALF);
  endtask

  task automatic ss_end();
    #(HALF);
    spi_ss = 1'b1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    ss_begin();
    send_syms(a, 16);
    send_syms(d, 16);
    ss_end();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                         output logic [7:0] tr, output logic tr_oe);
    ss_begin();
    send_syms(a, 16);
    turnaround(tr, tr_oe);
    recv_word(data);
    ss_end();
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n    = 1'b0;
    spi_clk  = 1'b0;
    spi_ss   = 1'b1;
    spi_d_in = 2'b00;
    #1;
    n_checks++;
    if ({spi_d_out, spi_d_oe, bus_addr, bus_wdata, bus_wr, bus_rd, frame_err} !== '0)
      $display("FAIL reset_during: outputs %h expected 0",
               {spi_d_out, spi_d_oe, bus_addr, bus_wdata, bus_wr, bus_rd, frame_err});
    else n_pass++;
    settle(5);
    rst_n = 1'b1;
    settle(10);
    n_checks++;
    if ({spi_d_out, spi_d_oe, bus_addr, bus_wdata, bus_wr, bus_rd, frame_err} !== '0)
      $display("FAIL reset_after: outputs %h expected 0",
               {spi_d_out, spi_d_oe, bus_addr, bus_wdata, bus_wr, bus_rd, frame_err});
    else n_pass++;
  endtask

  task automatic check_txns(input string name);
    logic [64:0] g;
    logic [64:0] e;
    n_checks++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL %s_count: got %0d transactions expected %0d", name,
               got_q.size(), exp_q.size());
    else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) $display("FAIL %s_txn: got %h expected %h", name, g, e);
      else n_pass++;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_write();
    logic [31:0] a;
    logic [31:0] d;
    int f0;
    int w0;
    ack_en    = 1'b1;
    ack_delay = 3;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        a = 32'hF800_0011;
        d = 32'h1234_5678;
      end else begin
        a = $urandom | 32'h1;
        d = $urandom;
      end
      f0 = ferr_cnt;
      w0 = wr_hi;
      exp_q.push_back({1'b1, a & ~32'h1, d});
      do_write(a, d);
      settle(20);
      check_txns("write");
      n_checks++;
      if (wr_hi - w0 !== ack_delay + 1)
        $display("FAIL write_hold: bus_wr high %0d cycles expected %0d",
                 wr_hi - w0, ack_delay + 1);
      else n_pass++;
      n_checks++;
      if (ferr_cnt - f0 !== 0)
        $display("FAIL write_ferr: %0d pulses expected 0", ferr_cnt - f0);
      else n_pass++;
    end
  endtask

  task automatic test_read();
    logic [31:0] a;
    logic [31:0] data;
    logic [7:0]  tr;
    logic        tr_oe;
    int f0;
    ack_en    = 1'b1;
    ack_delay = 3;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        a        = 32'hF800_0000;
        rd_value = 32'hCAFE_0001;
      end else begin
        a        = $urandom & ~32'h1;
        rd_value = $urandom;
      end
      f0 = ferr_cnt;
      exp_q.push_back({1'b0, a, 32'h0});
      do_read(a, data, tr, tr_oe);
      n_checks++;
      if (tr !== 8'h00 || tr_oe !== 1'b1)
        $display("FAIL read_turn: bits %h oe %b expected 00 oe 1", tr, tr_oe);
      else n_pass++;
      n_checks++;
      if (data !== rd_value)
        $display("FAIL read_data: got %h expected %h", data, rd_value);
      else n_pass++;
      settle(8);
      n_checks++;
      if (spi_d_oe !== 1'b0)
        $display("FAIL read_oe_drop: oe %b expected 0", spi_d_oe);
      else n_pass++;
      n_checks++;
      if (ferr_cnt - f0 !== 0)
        $display("FAIL read_ferr: %0d pulses expected 0", ferr_cnt - f0);
      else n_pass++;
      check_txns("read");
    end
  endtask

  task automatic test_late_read();
    logic [31:0] a;
    logic [31:0] data;
    logic [7:0]  tr;
    logic        tr_oe;
    int  f0;
    bit  dropped;
    a        = $urandom & ~32'h1;
    rd_value = $urandom | 32'h1;
    ack_en   = 1'b0;
    f0       = ferr_cnt;
    do_read(a, data, tr, tr_oe);
    n_checks++;
    if (data !== 32'h0)
      $display("FAIL late_data: got %h expected 00000000", data);
    else n_pass++;
    n_checks++;
    if (ferr_cnt - f0 !== 1)
      $display("FAIL late_ferr: %0d pulses expected 1", ferr_cnt - f0);
    else n_pass++;
    settle(10);
    n_checks++;
    if (bus_rd !== 1'b1)
      $display("FAIL late_rd_held: bus_rd %b expected 1", bus_rd);
    else n_pass++;
    exp_q.push_back({1'b0, a, 32'h0});
    ack_en  = 1'b1;
    dropped = 1'b0;
    for (int c = 0; c < 50 && !dropped; c++) begin
      settle(1);
      if (bus_rd === 1'b0) dropped = 1'b1;
    end
    n_checks++;
    if (!dropped) $display("FAIL late_rd_release: bus_rd 1 after 50 cycles expected 0");
    else n_pass++;
    settle(4);
    check_txns("late");
    n_checks++;
    if (ferr_cnt - f0 !== 1)
      $display("FAIL late_ferr_total: %0d pulses expected 1", ferr_cnt - f0);
    else n_pass++;
  endtask

  task automatic test_short_write();
    logic [31:0] a;
    logic [31:0] d;
    int f0;
    int w0;
    ack_en    = 1'b1;
    ack_delay = 2;
    a  = $urandom | 32'h1;
    d  = $urandom;
    f0 = ferr_cnt;
    w0 = wr_hi;
    ss_begin();
    send_syms(a, 16);
    send_syms(d, 8);
    ss_end();
    settle(20);
    check_txns("short");
    n_checks++;
    if (wr_hi - w0 !== 0)
      $display("FAIL short_no_wr: bus_wr high %0d cycles expected 0", wr_hi - w0);
    else n_pass++;
    n_checks++;
    if (ferr_cnt - f0 !== 1)
      $display("FAIL short_ferr: %0d pulses expected 1", ferr_cnt - f0);
    else n_pass++;
    a = $urandom | 32'h1;
    d = $urandom;
    exp_q.push_back({1'b1, a & ~32'h1, d});
    do_write(a, d);
    settle(20);
    check_txns("short_next");
    n_checks++;
    if (ferr_cnt - f0 !== 1)
      $display("FAIL short_next_ferr: %0d pulses expected 1", ferr_cnt - f0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  tr;
    logic        tr_oe;
    ack_en = 1'b0;
    a = $urandom & ~32'h1;
    ss_begin();
    send_syms(a, 16);
    turnaround(tr, tr_oe);
    settle(1);
    n_checks++;
    if (bus_rd !== 1'b1)
      $display("FAIL rst_pre_rd: bus_rd %b expected 1", bus_rd);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({spi_d_out, spi_d_oe, bus_addr, bus_wdata, bus_wr, bus_rd, frame_err} !== '0)
      $display("FAIL rst_mid_outputs: %h expected 0",
               {spi_d_out, spi_d_oe, bus_addr, bus_wdata, bus_wr, bus_rd, frame_err});
    else n_pass++;
    spi_ss = 1'b1;
    settle(4);
    rst_n  = 1'b1;
    ack_en = 1'b1;
    settle(10);
    check_txns("rst_pending");
    a = $urandom | 32'h1;
    d = $urandom;
    exp_q.push_back({1'b1, a & ~32'h1, d});
    do_write(a, d);
    settle(20);
    check_txns("rst_next");
  endtask

  task automatic test_back_to_back();
    logic [31:0] aw;
    logic [31:0] dw;
    logic [31:0] ar;
    logic [31:0] data;
    logic [7:0]  tr;
    logic        tr_oe;
    ack_en    = 1'b1;
    ack_delay = 1;
    aw        = $urandom | 32'h1;
    dw        = $urandom;
    ar        = $urandom & ~32'h1;
    rd_value  = $urandom;
    exp_q.push_back({1'b1, aw & ~32'h1, dw});
    exp_q.push_back({1'b0, ar, 32'h0});
    ss_begin();
    send_syms(aw, 16);
    send_syms(dw, 16);
    ss_end();
    settle(2);
    ss_begin();
    send_syms(ar, 16);
    turnaround(tr, tr_oe);
    recv_word(data);
    ss_end();
    settle(10);
    n_checks++;
    if (data !== rd_value)
      $display("FAIL b2b_read_data: got %h expected %h", data, rd_value);
    else n_pass++;
    check_txns("b2b");
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_write();
    test_read();
    test_late_read();
    test_short_write();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
